// File: rtl/ahb_gpio_pkg.sv
// Shared definitions for the multi-port AHB-Lite GPIO slave.
//   - HTRANS encodings
//   - per-port register offsets (word index within a port block)
//   - port block stride in bytes
//   - registered address-phase record passed from address to data phase
package ahb_gpio_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // Word index of each register inside a port block (HADDR[4:2])
    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_DIR     = 3'd1;
    localparam logic [2:0] REG_INTEN   = 3'd2;
    localparam logic [2:0] REG_INTTYPE = 3'd3;
    localparam logic [2:0] REG_INTSTAT = 3'd4;

    localparam logic [31:0] PORT_STRIDE = 32'h20;
    localparam int          PORT_SHIFT  = $clog2(PORT_STRIDE);

    typedef struct packed {
        logic       valid;
        logic       write;
        logic [2:0] port;
        logic [2:0] reg_sel;
    } addr_phase_t;

endpackage

// File: rtl/gpio_port_ctrl.sv
// One GPIO port: DATA/DIR/INTEN/INTTYPE/INTSTAT registers, input synchroniser,
// edge detector and a level IRQ.
//   clk, rst          clock and asynchronous active-high reset
//   armed             edge detection enable from the shared arm counter
//   wr_en             data-phase write strobe addressed to this port
//   reg_sel           register index of the current data phase
//   wr_data           write data (port width)
//   gpio_in           pad inputs
//   rd_data           read data for reg_sel
//   gpio_out, gpio_oe output register and output enable (= DIR)
//   irq               OR of the interrupt status bits
module gpio_port_ctrl
    import ahb_gpio_pkg::*;
#(
    parameter int PORT_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  armed,
    input  logic                  wr_en,
    input  logic [2:0]            reg_sel,
    input  logic [PORT_WIDTH-1:0] wr_data,
    input  logic [PORT_WIDTH-1:0] gpio_in,
    output logic [PORT_WIDTH-1:0] rd_data,
    output logic [PORT_WIDTH-1:0] gpio_out,
    output logic [PORT_WIDTH-1:0] gpio_oe,
    output logic                  irq
);

    logic [PORT_WIDTH-1:0] data_q, dir_q, inten_q, inttype_q, intstat_q, intstat_d;
    logic [PORT_WIDTH-1:0] prev_q, sync_val, edge_hit;
    // Stage 1 lives in the low slice; the oldest stage is the top slice.
    logic [SYNC_STAGES*PORT_WIDTH-1:0] sync_q;

    assign sync_val = sync_q[SYNC_STAGES*PORT_WIDTH-1 -: PORT_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            dir_q     <= '0;
            inten_q   <= '0;
            inttype_q <= '0;
            intstat_q <= '0;
            sync_q    <= '0;
            prev_q    <= '0;
        end else begin
            if (wr_en && reg_sel == REG_DATA)    data_q    <= wr_data;
            if (wr_en && reg_sel == REG_DIR)     dir_q     <= wr_data;
            if (wr_en && reg_sel == REG_INTEN)   inten_q   <= wr_data;
            if (wr_en && reg_sel == REG_INTTYPE) inttype_q <= wr_data;
            sync_q    <= {sync_q[(SYNC_STAGES-1)*PORT_WIDTH-1:0], gpio_in};
            prev_q    <= sync_val;
            intstat_q <= intstat_d;
        end
    end

    always_comb begin
        edge_hit = '0;
        if (armed) begin
            edge_hit = inten_q & ((inttype_q & sync_val & ~prev_q) |
                                  (~inttype_q & ~sync_val & prev_q));
        end
        intstat_d = intstat_q;
        if (wr_en && reg_sel == REG_INTSTAT) begin
            intstat_d = intstat_q & ~wr_data;
        end
        // A new edge overrides a simultaneous clear of the same bit
        intstat_d = intstat_d | edge_hit;
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            REG_DATA:    rd_data = (dir_q & data_q) | (~dir_q & sync_val);
            REG_DIR:     rd_data = dir_q;
            REG_INTEN:   rd_data = inten_q;
            REG_INTTYPE: rd_data = inttype_q;
            REG_INTSTAT: rd_data = intstat_q;
            default:     rd_data = '0;
        endcase
    end

    assign gpio_out = data_q;
    assign gpio_oe  = dir_q;
    assign irq      = |intstat_q;

endmodule

// File: rtl/ahb_gpio_multi.sv
// AHB-Lite GPIO slave with NUM_PORTS ports of PORT_WIDTH bits, zero wait state.
//   HCLK, RESET                bus clock, asynchronous active-high reset
//   HSEL/HADDR/HTRANS/HWRITE   address phase (HSIZE ignored, word accesses)
//   HWDATA, HREADY             write data, bus ready
//   HRDATA, HREADYOUT, HRESP   read data, always ready, always OKAY
//   GPIOIN/GPIOOUT/GPIOOE      packed per port, port p at [p*PORT_WIDTH +: PORT_WIDTH]
//   IRQ                        per-port level interrupt
// Port block p at byte offset p*0x20; register index at HADDR[4:2].
module ahb_gpio_multi
    import ahb_gpio_pkg::*;
#(
    parameter int NUM_PORTS   = 2,
    parameter int PORT_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                            HCLK,
    input  logic                            RESET,
    input  logic                            HSEL,
    input  logic [31:0]                     HADDR,
    input  logic [1:0]                      HTRANS,
    input  logic                            HWRITE,
    input  logic [2:0]                      HSIZE,
    input  logic [31:0]                     HWDATA,
    input  logic                            HREADY,
    output logic [31:0]                     HRDATA,
    output logic                            HREADYOUT,
    output logic                            HRESP,
    input  logic [NUM_PORTS*PORT_WIDTH-1:0] GPIOIN,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] GPIOOUT,
    output logic [NUM_PORTS*PORT_WIDTH-1:0] GPIOOE,
    output logic [NUM_PORTS-1:0]            IRQ
);

    localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0]  ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    addr_phase_t           addr_q, addr_d;
    logic [ARM_W-1:0]      arm_q;
    logic                  armed;
    logic [PORT_WIDTH-1:0] wr_data;
    logic [PORT_WIDTH-1:0] port_rdata [NUM_PORTS];
    logic                  unused_bits;

    // Address phase: anything other than a selected NONSEQ/SEQ with HREADY
    // clears the record, so no stale data phase can commit.
    always_comb begin
        addr_d = '0;
        if (HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ)) begin
            addr_d.valid   = 1'b1;
            addr_d.write   = HWRITE;
            addr_d.port    = HADDR[PORT_SHIFT +: 3];
            addr_d.reg_sel = HADDR[4:2];
        end
    end

    always_ff @(posedge HCLK or posedge RESET) begin
        if (RESET) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    // Holds off edge detection until the synchroniser and previous flop have
    // been filled with real input levels after reset.
    assign armed = (arm_q == ARM_DONE);

    always_ff @(posedge HCLK or posedge RESET) begin
        if (RESET) begin
            arm_q <= '0;
        end else if (!armed) begin
            arm_q <= arm_q + 1'b1;
        end
    end

    assign wr_data = HWDATA[PORT_WIDTH-1:0];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic wr_en;
        assign wr_en = addr_q.valid && addr_q.write && (addr_q.port == 3'(p));

        gpio_port_ctrl #(
            .PORT_WIDTH  (PORT_WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_port (
            .clk      (HCLK),
            .rst      (RESET),
            .armed    (armed),
            .wr_en    (wr_en),
            .reg_sel  (addr_q.reg_sel),
            .wr_data  (wr_data),
            .gpio_in  (GPIOIN[p*PORT_WIDTH +: PORT_WIDTH]),
            .rd_data  (port_rdata[p]),
            .gpio_out (GPIOOUT[p*PORT_WIDTH +: PORT_WIDTH]),
            .gpio_oe  (GPIOOE[p*PORT_WIDTH +: PORT_WIDTH]),
            .irq      (IRQ[p])
        );
    end

    // Ports beyond NUM_PORTS match no entry and read as zero
    always_comb begin
        HRDATA = '0;
        if (addr_q.valid && !addr_q.write) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (addr_q.port == 3'(p)) begin
                    HRDATA[PORT_WIDTH-1:0] = port_rdata[p];
                end
            end
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    assign unused_bits = ^{HSIZE, HADDR, HTRANS, HWDATA};

endmodule

// File: doc/ahb_gpio_multi.md
Name: ahb_gpio_multi

Overview:
- Parametrised AHB-Lite GPIO slave; successor to the single fixed 16-bit GPIO peripheral.
- Provides NUM_PORTS independent ports of PORT_WIDTH bits each.
- Each port has a per-bit direction register, input synchroniser, per-bit edge-triggered interrupts with write-1-to-clear status, and one IRQ line.
- Sits on the system AHB-Lite bus behind the address decoder/mux, in place of the current GPIO slot.

Parameters:
NUM_PORTS, 2, number of GPIO ports (1..8)
PORT_WIDTH, 16, bits per port (1..32)
SYNC_STAGES, 2, input synchroniser depth (2..4)

Ports:
HCLK  in  1  bus clock
RESET  in  1  asynchronous reset, active-high
HSEL  in  1  slave select from decoder
HADDR  in  32  address
HTRANS  in  2  transfer type
HWRITE  in  1  1 = write
HSIZE  in  3  transfer size; ignored, all accesses treated as word
HWDATA  in  32  write data
HREADY  in  1  bus ready
HRDATA  out  32  read data
HREADYOUT  out  1  always 1 (zero wait state)
HRESP  out  1  always 0
GPIOIN  in  NUM_PORTS*PORT_WIDTH  pad inputs, port p at [p*PORT_WIDTH +: PORT_WIDTH]
GPIOOUT  out  NUM_PORTS*PORT_WIDTH  output data registers
GPIOOE  out  NUM_PORTS*PORT_WIDTH  output enables (= DIR)
IRQ  out  NUM_PORTS  per-port interrupt, level

Behaviour:
- Address phase accepted when HSEL & HREADY & HTRANS[1]. Registered fields: port = HADDR[7:5], reg = HADDR[4:2], write flag, valid.
- Write commits at the HCLK edge ending the data phase, using HWDATA[PORT_WIDTH-1:0]. Upper bits are ignored.
- Read data is combinational from the registered address during the data phase. Unused upper bits read 0.
- A read in the data phase immediately after a write to the same register returns the new value.
- Register map per port (offset from port base, port stride 0x20):
  - 0x00 DATA: write sets the output register (all bits, regardless of DIR). Read returns, per bit, DIR ? output reg : synchronised input.
  - 0x04 DIR: 1 = output.
  - 0x08 INTEN: per-bit interrupt enable.
  - 0x0C INTTYPE: 1 = rising edge, 0 = falling edge.
  - 0x10 INTSTAT: read status; write 1 clears the bit, write 0 has no effect.
  - 0x14–0x1C: read 0, writes ignored.
- Port index >= NUM_PORTS: reads return 0, writes are ignored, no error response.
- Input path: GPIOIN passes through SYNC_STAGES flops, then one "previous" flop for edge detection.
- INTSTAT bit sets when INTEN=1 and the synchronised edge matches INTTYPE. Inputs on DIR=1 bits still generate edges.
- Set and W1C on the same bit in the same cycle: set wins, and the bit stays 1.
- IRQ[p] = |INTSTAT[p]; it is registered-derived, with no combinational path from GPIOIN.
- Edge-arm counter: after RESET deasserts, edge detection is inhibited for SYNC_STAGES+1 cycles, counted by a saturating counter. Input levels present at reset release therefore never raise spurious interrupts.
- Reset values: all registers, sync flops, the previous flop and the arm counter are 0. Consequently GPIOOUT=0, GPIOOE=0, IRQ=0, HRDATA=0, HREADYOUT=1, HRESP=0.
- RESET asserted mid-transfer: any pending data phase is discarded and no write commits.
- IDLE/BUSY transfers, or HREADY=0: no address capture, and the registered valid flag clears.

Decomposition:
- Package ahb_gpio_pkg: HTRANS encodings, register offset constants (REG_DATA..REG_INTSTAT), PORT_STRIDE, and a typedef for the registered address-phase struct (valid, write, port, reg).
- Sub-module gpio_port_ctrl: one instance per port in a generate loop. It holds the DATA/DIR/INTEN/INTTYPE/INTSTAT registers, the synchroniser, the edge detector and the IRQ output.
- Top level: AHB address-phase register, the write-strobe decode to the ports, the read mux, and the shared arm counter.

Test Plan:
- Reset, then write port0 DIR=0x00FF and DATA=0xA5A5 → GPIOOUT[15:0]=0xA5A5 and GPIOOE[15:0]=0x00FF. With GPIOIN[15:0]=0x3C00, a DATA read returns 0x3CA5.
- Port1 INTEN=0x0001, INTTYPE=0x0001; drive GPIOIN[16] 0→1 → INTSTAT[1]=0x0001, and IRQ[1] rises exactly SYNC_STAGES+1 cycles after the pin change. Writing INTSTAT=0x0001 clears IRQ[1].
- Falling-edge case: INTTYPE=0 on bit 3 with GPIOIN bit 3 going 1→0 → status bit 3 sets. A rising edge on the same bit does not set it.
- W1C collides with a new edge in the same cycle → INTSTAT bit remains 1 and IRQ stays high.
- Hold GPIOIN all-ones through reset release with INTEN written to 0xFFFF → no INTSTAT bits set. An access to port index 5 (NUM_PORTS=2) reads 0, and its write leaves all port registers unchanged.
- Assert RESET during the data phase of a DATA write of 0xFFFF → GPIOOUT=0 after reset. Back-to-back write-then-read of DIR returns the written value with HREADYOUT=1 throughout.
